ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: word-address width of every address port.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  requester 0 access request; held until granted.
REQ-005 m0_wr_en  input  1  1 = write, 0 = read.
REQ-006 m0_wr_strobe  input  4  byte enables for writes.
REQ-007 m0_addr  input  ADDR_WIDTH  access address.
REQ-008 m0_data_in  input  32  write data.
REQ-009 m0_gnt  output  1  request accepted this cycle.
REQ-010 m0_rvalid  output  1  read data valid.
REQ-011 m0_data_out  output  32  read data.
REQ-012 m1_* ports SHALL mirror REQ-004..REQ-011 for requester 1.
REQ-013 ram_wr_en  output  1, ram_wr_strobe  output  4, ram_addr  output  ADDR_WIDTH, ram_data_in  output  32: command to one port of the shared synchronous RAM.
REQ-014 ram_data_out  input  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-015 Per cycle, at most one requester SHALL be granted; gnt is combinational from req and the priority state.
REQ-016 One requester active: it SHALL be granted in the same cycle.
REQ-017 Both requesting: grant SHALL go to the requester not granted most recently (round-robin); last_grant updates on every grant.
REQ-018 The granted requester's wr_en, wr_strobe, addr and data_in SHALL drive ram_* combinationally in the grant cycle.
REQ-019 No grant: ram_wr_en = 0, ram_wr_strobe = 0, ram_addr = 0, ram_data_in = 0.
REQ-020 Granted write: ram_wr_en = 1 for exactly that cycle; no rvalid produced.
REQ-021 Granted read: a pending flag and 1-bit owner SHALL be registered; in the next cycle the owner's rvalid = 1 for one cycle and its data_out = ram_data_out.
REQ-022 data_out SHALL be 0 whenever that port's rvalid = 0.
REQ-023 Back-to-back reads SHALL be accepted every cycle (throughput 1/cycle); the rvalid of access N and the grant of access N+1 may coincide.
REQ-024 The arbiter SHALL not insert idle cycles; a port requesting continuously alone is granted every cycle.
REQ-025 Under continuous contention, grants SHALL alternate strictly m0, m1, m0, ...; neither requester waits more than one cycle.
REQ-026 A requester dropping req before grant SHALL cause no RAM access and no state change.

Reset
REQ-027 While reset_n = 0: all gnt, rvalid, data_out and ram_* outputs = 0; pending = 0; last_grant = 1 (m0 wins the first tie).
REQ-028 Reset asserted with a read pending: the read SHALL be discarded; no rvalid after reset release.
REQ-029 The first grant SHALL be possible in the first clock edge after reset_n deasserts.

Verification
REQ-030 Bench SHALL cover: after reset, m0 and m1 both read, addr 0x0010 / 0x0020 -> m0_gnt in cycle 0, m1_gnt in cycle 1; m0_rvalid in cycle 1, m1_rvalid in cycle 2, each with the RAM word at its address.
REQ-031 Bench SHALL cover: m1 writes 0xDEADBEEF, strobe 0xF, addr 0x0004, then m0 reads 0x0004 -> ram_wr_en pulse of 1 cycle; m0_data_out = 0xDEADBEEF with m0_rvalid.
REQ-032 Bench SHALL cover: both requesting for 8 cycles -> grants alternate m0, m1 four times each; no cycle without a grant.
REQ-033 Bench SHALL cover: m0 alone reads 4 consecutive addresses -> 4 consecutive grants, 4 consecutive rvalid cycles, data in order.
REQ-034 Bench SHALL cover: reset_n low in the cycle after a m1 read grant -> no m1_rvalid; all outputs 0; first tie afterwards goes to m0.
REQ-035 Bench SHALL cover: byte write, strobe 0x2, data 0x0000AB00, over word 0x11223344 -> readback 0x1122AB44.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of one port of a synchronous RAM.
// Grants are combinational; read data is routed back to its owner one cycle later.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  m0_req,
  input  logic                  m0_wr_en,
  input  logic [3:0]            m0_wr_strobe,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_data_in,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_data_out,

  input  logic                  m1_req,
  input  logic                  m1_wr_en,
  input  logic [3:0]            m1_wr_strobe,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_data_in,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_data_out,

  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  // Handshake: req is held until gnt; gnt high means the command is on ram_*
  // this cycle. A granted read returns rvalid/data_out exactly one cycle later.

  logic last_grant_q, last_grant_d;  // 1 = m1 granted most recently
  logic pending_q, pending_d;
  logic owner_q, owner_d;

  // Gating with reset_n keeps every combinational output quiet during reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset_n) begin
      m0_gnt = m0_req && (!m1_req || last_grant_q);
      m1_gnt = m1_req && (!m0_req || !last_grant_q);
    end
  end

  always_comb begin
    ram_wr_en     = 1'b0;
    ram_wr_strobe = '0;
    ram_addr      = '0;
    ram_data_in   = '0;
    if (m0_gnt) begin
      ram_wr_en     = m0_wr_en;
      ram_wr_strobe = m0_wr_strobe;
      ram_addr      = m0_addr;
      ram_data_in   = m0_data_in;
    end else if (m1_gnt) begin
      ram_wr_en     = m1_wr_en;
      ram_wr_strobe = m1_wr_strobe;
      ram_addr      = m1_addr;
      ram_data_in   = m1_data_in;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    pending_d    = 1'b0;
    owner_d      = owner_q;
    if (m0_gnt || m1_gnt) begin
      last_grant_d = m1_gnt;
      pending_d    = !ram_wr_en;
      owner_d      = m1_gnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      pending_q    <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      owner_q      <= owner_d;
    end
  end

  assign m0_rvalid   = pending_q && !owner_q;
  assign m1_rvalid   = pending_q && owner_q;
  assign m0_data_out = m0_rvalid ? ram_data_out : 32'h0;
  assign m1_data_out = m1_rvalid ? ram_data_out : 32'h0;

endmodule
